// File: rtl/alu_seq.sv
// Registered ALU with a valid/ready handshake and a shift-add multiplier.
// It holds the result and the N/Z/C/V flags until they are consumed, and keeps a carry for add-with-carry chains.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NAND = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_PASS = 4'd12;
  localparam logic [3:0] OP_ADDC = 4'd13;
  localparam logic [3:0] OP_ROL  = 4'd14;

  logic [1:0]         state;
  logic [WIDTH-1:0]   res_q;
  logic [3:0]         flags_q;
  logic               err_q;
  logic               carry_q;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [SHW:0]       count;

  logic [SHW-1:0]     sh;
  logic [SHW:0]       rol_back;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic [WIDTH:0]     addc_sum;
  logic [WIDTH:0]     shl_wide;
  logic [WIDTH:0]     shr_wide;
  logic [WIDTH-1:0]   sra_res;
  logic [WIDTH-1:0]   rol_res;
  logic               add_v;
  logic               sub_v;
  logic               addc_v;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic               alu_err;
  logic               alu_upd;

  logic [2*WIDTH-1:0] mul_acc_next;
  logic               mul_last;
  logic               mul_c;

  assign sh = B[SHW-1:0];

  // The extra top bit of each sum catches the carry-out.
  // For the subtraction, that bit is the borrow, which is set exactly when A < B.
  always_comb begin
    add_sum  = {1'b0, A} + {1'b0, B};
    sub_diff = {1'b0, A} - {1'b0, B};
    addc_sum = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, carry_q};
    add_v    = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
    sub_v    = (A[WIDTH-1] != B[WIDTH-1]) && (sub_diff[WIDTH-1] != A[WIDTH-1]);
    addc_v   = (A[WIDTH-1] == B[WIDTH-1]) && (addc_sum[WIDTH-1] != A[WIDTH-1]);
  end

  // Widened shifts put the last bit shifted out at a fixed position, and that bit is 0 when sh is 0.
  // A rotate by 0 shifts right by WIDTH, so it returns A unchanged.
  always_comb begin
    shl_wide = {1'b0, A} << sh;
    shr_wide = {A, 1'b0} >> sh;
    sra_res  = $signed(A) >>> sh;
    rol_back = (SHW+1)'(WIDTH) - {1'b0, sh};
    rol_res  = (A << sh) | (A >> rol_back);
  end

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    alu_upd = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_c   = add_sum[WIDTH];
        alu_v   = add_v;
        alu_upd = 1'b1;
      end
      OP_SUB: begin
        alu_res = sub_diff[WIDTH-1:0];
        alu_c   = sub_diff[WIDTH];
        alu_v   = sub_v;
        alu_upd = 1'b1;
      end
      OP_OR:   alu_res = A | B;
      OP_AND:  alu_res = A & B;
      OP_XOR:  alu_res = A ^ B;
      OP_NAND: alu_res = ~(A & B);
      OP_NOR:  alu_res = ~(A | B);
      OP_NOT:  alu_res = ~A;
      OP_SHL: begin
        alu_res = shl_wide[WIDTH-1:0];
        alu_c   = shl_wide[WIDTH];
        alu_upd = 1'b1;
      end
      OP_SHR: begin
        alu_res = shr_wide[WIDTH:1];
        alu_c   = shr_wide[0];
        alu_upd = 1'b1;
      end
      OP_SRA: begin
        alu_res = sra_res;
        alu_c   = shr_wide[0];
        alu_upd = 1'b1;
      end
      OP_PASS: alu_res = A;
      OP_ADDC: begin
        alu_res = addc_sum[WIDTH-1:0];
        alu_c   = addc_sum[WIDTH];
        alu_v   = addc_v;
        alu_upd = 1'b1;
      end
      OP_ROL:  alu_res = rol_res;
      OP_MUL:  alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  // The result is taken from the accumulator after the final step, so the multiply ends on the WIDTH-th step itself.
  always_comb begin
    mul_acc_next = mplier[0] ? (acc + mcand) : acc;
    mul_last     = (count == {{SHW{1'b0}}, 1'b1});
    mul_c        = |mul_acc_next[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
      carry_q <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (op == OP_MUL) begin
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, A};
              mplier <= B;
              count  <= (SHW+1)'(WIDTH);
              state  <= MUL;
            end else begin
              res_q <= alu_res;
              err_q <= alu_err;
              if (alu_err) begin
                flags_q <= 4'b0000;
              end else begin
                flags_q <= {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
              end
              if (alu_upd) begin
                carry_q <= alu_c;
              end
              state <= DONE;
            end
          end
        end
        MUL: begin
          acc    <= mul_acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - 1'b1;
          if (mul_last) begin
            res_q   <= mul_acc_next[WIDTH-1:0];
            flags_q <= {mul_acc_next[WIDTH-1], (mul_acc_next[WIDTH-1:0] == '0), mul_c, 1'b0};
            err_q   <= 1'b0;
            carry_q <= mul_c;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign res       = res_q;
  assign flags     = flags_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq.
// It runs a directed vector table, then randomized operations checked against an arithmetic reference model, then the backpressure and reset-abort sequences.
module tb_alu_seq;

  localparam int WIDTH = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op;
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  B;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  res;
  logic [3:0]        flags;
  logic              err;

  int   checks = 0;
  int   fails  = 0;
  logic model_carry;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .flags     (flags),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [3:0]  flags;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model built from plain integer arithmetic on the operand values
  function automatic void model(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                                input logic cin, output logic [15:0] r, output logic [3:0] f,
                                output logic e, output logic upd, output logic cout);
    longint ua, ub, sa, sb, full, sfull, q, p2;
    int     sh;
    logic   c, v;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    sh = int'(ub % 16);
    p2 = longint'(1) << sh;
    c = 1'b0; v = 1'b0; e = 1'b0; upd = 1'b0; r = 16'h0;
    case (o)
      4'd0, 4'd13: begin
        full  = ua + ub + ((o == 4'd13) ? longint'(cin) : 0);
        sfull = sa + sb + ((o == 4'd13) ? longint'(cin) : 0);
        r = 16'(full); c = (full > 65535); v = (sfull > 32767) || (sfull < -32768); upd = 1'b1;
      end
      4'd1: begin
        full = ua - ub; sfull = sa - sb;
        r = 16'(full); c = (ua < ub); v = (sfull > 32767) || (sfull < -32768); upd = 1'b1;
      end
      4'd2:  r = a | b;
      4'd3:  r = a & b;
      4'd4:  r = a ^ b;
      4'd5:  r = ~(a & b);
      4'd6:  r = ~(a | b);
      4'd7:  r = ~a;
      4'd8: begin
        full = ua * p2;
        r = 16'(full); c = ((full / 65536) % 2) == 1; upd = 1'b1;
      end
      4'd9: begin
        r = 16'(ua / p2); c = (sh != 0) && (((ua / (p2 / 2)) % 2) == 1); upd = 1'b1;
      end
      4'd10: begin
        q = sa / p2;
        if (sa < 0 && q * p2 != sa) q = q - 1;
        r = 16'(q); c = (sh != 0) && (((ua / (p2 / 2)) % 2) == 1); upd = 1'b1;
      end
      4'd11: begin
        full = ua * ub;
        r = 16'(full); c = (full > 65535); upd = 1'b1;
      end
      4'd12: r = a;
      4'd14: r = (sh == 0) ? a : 16'((ua * p2) + (ua / (longint'(1) << (16 - sh))));
      default: begin
        r = 16'h0; e = 1'b1;
      end
    endcase
    f    = e ? 4'b0000 : {r[15], (r == 16'h0), c, v};
    cout = c;
  endfunction

  // Hold the request until accepted, then count the cycles until out_valid rises
  task automatic applyStimulus(input logic [3:0] v_op, input logic [15:0] v_a, input logic [15:0] v_b,
                               output int lat, output logic busy_ready);
    int w;
    @(negedge clk);
    in_valid = 1'b1; op = v_op; A = v_a; B = v_b; out_ready = 1'b0;
    w = 0;
    busy_ready = 1'b0;
    lat = -1;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ready = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check("result_timeout", 32'd0, 32'd1);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] er, input logic [3:0] ef, input logic ee);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_res"}, 32'(res), 32'(er));
    check({name, "_flags"}, 32'(flags), 32'(ef));
    check({name, "_err"}, 32'(err), 32'(ee));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic runOp(input string name, input logic [3:0] v_op, input logic [15:0] v_a, input logic [15:0] v_b,
                       input logic [15:0] er, input logic [3:0] ef, input logic ee);
    int   lat;
    logic busy;
    applyStimulus(v_op, v_a, v_b, lat, busy);
    check({name, "_latency"}, 32'(lat), (v_op == 4'd11) ? 32'd17 : 32'd1);
    check({name, "_busy_ready"}, 32'(busy), 32'd0);
    checkOutput(name, er, ef, ee);
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0]  r_op;
    logic [15:0] r_a, r_b, m_res;
    logic [3:0]  m_flags;
    logic        m_err, m_upd, m_cout;
    int          stale;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 4'd0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_res", 32'(res), 32'd0);
    check("reset_flags", 32'(flags), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    // op, A, B, res, {N,Z,C,V}, err; the entries are applied in order, so the carry chain carries through
    vecs.push_back('{4'd0,  16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 1'b0});
    vecs.push_back('{4'd13, 16'h0000, 16'h0000, 16'h0001, 4'b0000, 1'b0});
    vecs.push_back('{4'd1,  16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 1'b0});
    vecs.push_back('{4'd1,  16'h0001, 16'h0002, 16'hFFFF, 4'b1010, 1'b0});
    vecs.push_back('{4'd11, 16'h0100, 16'h0100, 16'h0000, 4'b0110, 1'b0});
    vecs.push_back('{4'd11, 16'h0003, 16'h0005, 16'h000F, 4'b0000, 1'b0});
    vecs.push_back('{4'd10, 16'h8004, 16'h0002, 16'hE001, 4'b1000, 1'b0});
    vecs.push_back('{4'd8,  16'h8001, 16'h0001, 16'h0002, 4'b0010, 1'b0});
    vecs.push_back('{4'd14, 16'h8001, 16'h0004, 16'h0018, 4'b0000, 1'b0});
    vecs.push_back('{4'd15, 16'h1234, 16'h5678, 16'h0000, 4'b0000, 1'b1});
    vecs.push_back('{4'd13, 16'h0000, 16'h0000, 16'h0001, 4'b0000, 1'b0});
    vecs.push_back('{4'd7,  16'h00FF, 16'h1234, 16'hFF00, 4'b1000, 1'b0});
    vecs.push_back('{4'd12, 16'h0000, 16'hFFFF, 16'h0000, 4'b0100, 1'b0});
    vecs.push_back('{4'd9,  16'h0003, 16'h0001, 16'h0001, 4'b0010, 1'b0});
    vecs.push_back('{4'd5,  16'hFFFF, 16'hFFFF, 16'h0000, 4'b0100, 1'b0});
    vecs.push_back('{4'd4,  16'hAAAA, 16'h5555, 16'hFFFF, 4'b1000, 1'b0});
    vecs.push_back('{4'd2,  16'h0000, 16'h0000, 16'h0000, 4'b0100, 1'b0});
    vecs.push_back('{4'd3,  16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1'b0});
    vecs.push_back('{4'd6,  16'h0000, 16'h0000, 16'hFFFF, 4'b1000, 1'b0});
    vecs.push_back('{4'd8,  16'h1234, 16'h0010, 16'h1234, 4'b0000, 1'b0});
    vecs.push_back('{4'd0,  16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1'b0});
    vecs.push_back('{4'd14, 16'h1234, 16'h0000, 16'h1234, 4'b0000, 1'b0});
    vecs.push_back('{4'd9,  16'h8000, 16'h000F, 16'h0001, 4'b0000, 1'b0});
    vecs.push_back('{4'd10, 16'h8000, 16'h000F, 16'hFFFF, 4'b1000, 1'b0});

    foreach (vecs[i]) begin
      runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flags, vecs[i].err);
    end
    model_carry = 1'b0;

    $display("[TB] randomized phase");
    for (int i = 0; i < 250; i++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = 16'($urandom);
      r_b  = 16'($urandom);
      case ($urandom_range(0, 5))
        0: r_a = 16'hFFFF;
        1: r_a = 16'h8000;
        2: r_b = 16'($urandom_range(0, 1));
        default: ;
      endcase
      model(r_op, r_a, r_b, model_carry, m_res, m_flags, m_err, m_upd, m_cout);
      runOp($sformatf("rand%0d_op%0d", i, r_op), r_op, r_a, r_b, m_res, m_flags, m_err);
      if (m_upd) model_carry = m_cout;
    end

    $display("[TB] backpressure sequence");
    @(negedge clk);
    in_valid = 1'b1; op = 4'd0; A = 16'h1234; B = 16'h0001; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    A = 16'h0005; B = 16'h0005;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("bp_hold%0d_ready", i), 32'(in_ready), 32'd0);
      check($sformatf("bp_hold%0d_res", i), 32'(res), 32'h1235);
      check($sformatf("bp_hold%0d_flags", i), 32'(flags), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_after_handshake_valid", 32'(out_valid), 32'd0);
    check("bp_after_handshake_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_second_valid", 32'(out_valid), 32'd1);
    check("bp_second_res", 32'(res), 32'h000A);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    model_carry = 1'b0;

    $display("[TB] reset during multiply");
    runOp("pre_reset_add", 4'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; op = 4'd11; A = 16'h00FF; B = 16'h00FF;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_res", 32'(res), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("abort_no_stale_result", 32'(stale), 32'd0);
    runOp("post_reset_addc", 4'd13, 16'h0000, 16'h0000, 16'h0000, 4'b0100, 1'b0);

    $display("[TB] illegal opcode keeps carry");
    runOp("ill_setup_sub", 4'd1, 16'h0001, 16'h0002, 16'hFFFF, 4'b1010, 1'b0);
    runOp("ill_op", 4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0000, 1'b1);
    runOp("ill_addc", 4'd13, 16'h0001, 16'h0001, 16'h0003, 4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the combinational 16-bit ALU parts bin. Accepts one operation per valid/ready handshake: single-cycle logic/arith/shift ops, or a multi-cycle shift-add multiply. Holds result and N/Z/C/V flags until consumed. Keeps a carry register for chained add-with-carry. Sits between the operand/register stage and writeback in the datapath breadboard.

Parameters:
WIDTH, 16, operand/result width; power of two, >= 4
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  block can accept an operation
op  in  4  opcode (see Behaviour)
A  in  WIDTH  operand A
B  in  WIDTH  operand B; B[SHW-1:0] is the shift amount for shifts
out_valid  out  1  res/flags/err valid
out_ready  in  1  consumer accepts result
res  out  WIDTH  registered result
flags  out  4  {N,Z,C,V}
err  out  1  illegal opcode reported with this result

Behaviour:
- Reset (async on rst_n low): state IDLE; in_ready=1, out_valid=0, res=0, flags=0, err=0, carry_q=0. Reset mid-multiply aborts it; no result is produced.
- States: IDLE, MUL, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE: in_valid=1 accepts op/A/B. op=11 -> MUL, load acc=0, mcand=A, mplier=B, count=WIDTH. Any other op -> res/flags/err computed and registered same edge -> DONE (latency 1: out_valid high the cycle after acceptance).
- MUL: each cycle, if mplier[0] then acc += mcand (2*WIDTH-bit acc); mcand<<=1; mplier>>=1; count-=1. After WIDTH cycles register res=acc[WIDTH-1:0] -> DONE. out_valid rises exactly WIDTH+1 cycles after acceptance.
- DONE: res/flags/err held stable while out_ready=0. out_valid&&out_ready -> IDLE next cycle (no same-cycle accept of a new op; max throughput 1 op / 2 cycles).
- Opcodes (res): 0 ADD A+B; 1 SUB A-B; 2 OR; 3 AND; 4 XOR; 5 NAND; 6 NOR; 7 NOT A (B ignored); 8 SHL A<<sh; 9 SHR logical; 10 SRA arithmetic; 11 MUL low WIDTH bits; 12 PASS A; 13 ADDC A+B+carry_q; 14 ROL rotate A left by sh; 15 illegal: res=0, flags=0, err=1. err=0 for all others.
- Flags: Z=(res==0); N=res[WIDTH-1]; both valid for all legal ops.
- C: ADD/ADDC carry-out; SUB borrow (1 iff A<B unsigned); SHL last bit shifted out (A[WIDTH-sh]) if sh!=0 else 0; SHR/SRA last bit out (A[sh-1]) if sh!=0 else 0; MUL 1 iff acc[2*WIDTH-1:WIDTH]!=0; all others 0.
- V: ADD/ADDC/SUB signed overflow; all others 0.
- carry_q: updated with C when ADD, SUB, ADDC, SHL, SHR, SRA, MUL result is registered; unchanged by other ops and illegal op.
- sh=0 on any shift/rotate: res=A.
- in_valid while in_ready=0 is ignored; requester must hold until accepted.

Test Plan:
- WIDTH=16, ADD A=0xFFFF B=0x0001, out_ready=1 -> next cycle out_valid=1, res=0x0000, flags N=0 Z=1 C=1 V=0; then ADDC A=0 B=0 -> res=0x0001, C=0.
- SUB A=0x8000 B=0x0001 -> res=0x7FFF, N=0 Z=0 C=0 V=1; SUB A=0x0001 B=0x0002 -> res=0xFFFF, N=1 C=1 V=0.
- MUL A=0x0100 B=0x0100 -> in_ready=0 for 16 cycles, out_valid exactly 17 cycles after accept, res=0x0000, Z=1 C=1; MUL A=0x0003 B=0x0005 -> res=0x000F, C=0.
- Shifts: SRA A=0x8004 B=2 -> res=0xE001, C=0; SHL A=0x8001 B=1 -> res=0x0002, C=1; ROL A=0x8001 B=4 -> res=0x0018.
- Backpressure: ADD accepted, out_ready=0 for 5 cycles with in_valid=1 and new operands -> res/flags stable, in_ready=0, second op accepted only the cycle after out_ready=1 handshake.
- rst_n low 3 cycles into a MUL -> out_valid=0 immediately, in_ready=1, carry_q=0 after release, no stale result; op=15 -> res=0, flags=0, err=1, carry_q unchanged.
